// File: rtl/trivium_stream.sv
// Trivium keystream generator: runtime key/IV load, WIDTH steps per clock,
// INIT_ROUNDS warm-up steps, valid/ready keystream output.
module trivium_stream #(
    parameter int WIDTH       = 1,
    parameter int INIT_ROUNDS = 1152
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [79:0]      key_in,
    input  logic [79:0]      iv_in,
    input  logic             start,
    input  logic             stop,
    output logic             busy,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic [WIDTH-1:0] ks_data,
    output logic [1:0]       dbg_state_o
);

    localparam int CW = $clog2(INIT_ROUNDS) + 1;
    localparam logic [CW-1:0] CNT_STEP = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(INIT_ROUNDS - WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // Handshake: a word transfers on a rising edge where ks_valid & ks_ready;
    // ks_data and ks_valid hold steady while ks_valid & !ks_ready.

    state_t            state_q, state_d;
    logic [287:0]      s_q, s_d;        // s_q[i-1] holds s(i)
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              valid_q, valid_d;
    logic [287:0]      s_adv;
    logic [WIDTH-1:0]  z_w;
    logic [287:0]      s_load;

    // Returns {z, next_state} for one Trivium step.
    function automatic logic [288:0] trivium_step(input logic [287:0] s);
        logic t1, t2, t3, z;
        t1 = s[65] ^ s[92];
        t2 = s[161] ^ s[176];
        t3 = s[242] ^ s[287];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (s[90] & s[91]) ^ s[170];
        t2 = t2 ^ (s[174] & s[175]) ^ s[263];
        t3 = t3 ^ (s[285] & s[286]) ^ s[68];
        return {z, s[286:177], t2, s[175:93], t1, s[91:0], t3};
    endfunction

    always_comb begin
        s_load          = '0;
        s_load[79:0]    = key_in;
        s_load[172:93]  = iv_in;
        s_load[287:285] = 3'b111;
    end

    always_comb begin
        logic [288:0] r;
        s_adv = s_q;
        z_w   = '0;
        r     = '0;
        for (int j = 0; j < WIDTH; j++) begin
            r      = trivium_step(s_adv);
            z_w[j] = r[288];
            s_adv  = r[287:0];
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (start) begin
            s_d     = s_load;
            cnt_d   = '0;
            valid_d = 1'b0;
            state_d = ST_INIT;
        end else if (stop) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: valid_d = 1'b0;
                ST_INIT: begin
                    s_d   = s_adv;
                    cnt_d = cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Advance only when the held word is gone or being taken.
                    if (!valid_q || ks_ready) begin
                        s_d     = s_adv;
                        data_d  = z_w;
                        valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign busy        = (state_q == ST_INIT);
    assign ks_valid    = valid_q;
    assign ks_data     = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_trivium_stream.sv
// Scoreboard bench for trivium_stream: a bit-level Trivium model fills an
// expected-word queue on every start; a negedge monitor pops on each transfer.
module tb_trivium_stream;

    localparam int W  = 8;
    localparam int IR = 1152;
    localparam int NW = 48;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [79:0]   key_in = '0;
    logic [79:0]   iv_in = '0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          busy;
    logic          ks_valid;
    logic          ks_ready = 1'b0;
    logic [W-1:0]  ks_data;
    logic [1:0]    dbg_state_o;

    logic [W-1:0]  exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            acc_cnt = 0;
    bit            ms[1:288];

    trivium_stream #(.WIDTH(W), .INIT_ROUNDS(IR)) dut (
        .clk(clk), .rst(rst), .key_in(key_in), .iv_in(iv_in),
        .start(start), .stop(stop), .busy(busy), .ks_valid(ks_valid),
        .ks_ready(ks_ready), .ks_data(ks_data), .dbg_state_o(dbg_state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: eSTREAM-numbered bit array, one step at a time.
    task automatic model_step(output bit z);
        bit t1, t2, t3;
        t1 = ms[66] ^ ms[93];
        t2 = ms[162] ^ ms[177];
        t3 = ms[243] ^ ms[288];
        z  = t1 ^ t2 ^ t3;
        t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
        t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
        t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
        for (int k = 288; k > 178; k--) ms[k] = ms[k-1];
        ms[178] = t2;
        for (int k = 177; k > 94; k--) ms[k] = ms[k-1];
        ms[94] = t1;
        for (int k = 93; k > 1; k--) ms[k] = ms[k-1];
        ms[1] = t3;
    endtask

    task automatic model_fill(input logic [79:0] k, input logic [79:0] v);
        bit z;
        logic [W-1:0] w;
        for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            ms[i]      = k[i-1];
            ms[93 + i] = v[i-1];
        end
        ms[286] = 1'b1; ms[287] = 1'b1; ms[288] = 1'b1;
        for (int i = 0; i < IR; i++) model_step(z);
        exp_q.delete();
        for (int n = 0; n < NW; n++) begin
            w = '0;
            for (int j = 0; j < W; j++) begin
                model_step(z);
                w[j] = z;
            end
            exp_q.push_back(w);
        end
    endtask

    // Driver tasks: entered and left at posedge+#1.
    task automatic pulse_start(input logic [79:0] k, input logic [79:0] v, input bit with_stop);
        key_in = k;
        iv_in  = v;
        start  = 1'b1;
        stop   = with_stop;
        model_fill(k, v);
        @(posedge clk); #1;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        stop = 1'b0;
    endtask

    task automatic check_latency(input string tag);
        int edges = 0;
        int busy_cnt = 0;
        while (edges < 400) begin
            if (busy) busy_cnt++;
            if (ks_valid) break;
            @(posedge clk); #1;
            edges++;
        end
        check({tag, "_busy_cycles"}, busy_cnt, IR / W);
        check({tag, "_first_valid_edge"}, edges, IR / W + 1);
    endtask

    task automatic wait_words(input string tag, input int n, input bit rnd);
        int target = acc_cnt + n;
        int cyc = 0;
        while (acc_cnt < target && cyc < 3000) begin
            if (rnd) ks_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
        end
        ks_ready = 1'b1;
        check({tag, "_words_received"}, 64'(acc_cnt >= target), 64'd1);
    endtask

    task automatic idle_cycles(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_busy"}, busy, 1'b0);
            check({tag, "_valid"}, ks_valid, 1'b0);
            check({tag, "_state_idle"}, dbg_state_o, 2'd0);
            @(posedge clk); #1;
        end
    endtask

    // Monitor: decides at negedge what the next rising edge will transfer.
    bit           prev_stall = 1'b0;
    logic [W-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", ks_valid, 1'b1);
                check("stall_data_held", ks_data, prev_data);
            end
            prev_stall = ks_valid && !ks_ready && !start && !stop;
            prev_data  = ks_data;
            if (ks_valid && ks_ready && !start && !stop) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 64'(ks_data), 64'hDEAD);
                end else begin
                    check($sformatf("word_%0d", acc_cnt), ks_data, exp_q.pop_front());
                end
                acc_cnt++;
            end
        end
    end

    initial begin
        logic [79:0] k, v;
        // Reset held with start toggling.
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            key_in = {$urandom, $urandom, 16'($urandom)};
            @(posedge clk); #1;
            check("rst_valid", ks_valid, 1'b0);
            check("rst_busy", busy, 1'b0);
            check("rst_data", ks_data, '0);
            check("rst_state", dbg_state_o, 2'd0);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        idle_cycles("post_rst", 4);

        // Zero key/IV, full-rate consumption.
        ks_ready = 1'b1;
        pulse_start('0, '0, 1'b0);
        check_latency("zero_key");
        wait_words("zero_key", 32, 1'b0);

        // Random key/IV under random backpressure.
        ks_ready = 1'b0;
        k = {$urandom, $urandom, 16'($urandom)};
        v = {$urandom, $urandom, 16'($urandom)};
        pulse_start(k, v, 1'b0);
        check_latency("bp");
        wait_words("bp", 40, 1'b1);

        // Restart during RUN with a new key/IV.
        ks_ready = 1'b1;
        pulse_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 1'b0);
        wait_words("pre_restart", 6, 1'b0);
        pulse_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 1'b0);
        check("restart_valid_drop", ks_valid, 1'b0);
        check("restart_busy", busy, 1'b1);
        check_latency("restart");
        wait_words("restart", 32, 1'b1);

        // Stop alone in INIT.
        pulse_start({$urandom, $urandom, 16'($urandom)}, '0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        pulse_stop();
        idle_cycles("stop_init", 200);

        // Stop in RUN, then stop+start collision from RUN.
        pulse_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 1'b0);
        wait_words("pre_stop_run", 4, 1'b0);
        pulse_stop();
        idle_cycles("stop_run", 5);
        pulse_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 1'b0);
        wait_words("pre_collide", 5, 1'b1);
        pulse_start({$urandom, $urandom, 16'($urandom)}, {$urandom, $urandom, 16'($urandom)}, 1'b1);
        check("collide_busy", busy, 1'b1);
        check("collide_valid", ks_valid, 1'b0);
        check_latency("collide");
        wait_words("collide", 40, 1'b0);

        ks_ready = 1'b0;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
